// File: rtl/latch_wr_pkg.sv
// latch_wr_pkg: sequencer state encoding and phase-counter sizing shared by the latch write sequencer.
package latch_wr_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4
    } state_e;

    function automatic int cnt_w(input int s, input int p, input int h);
        int m;
        m = (s > p) ? s : p;
        m = (m > h) ? m : h;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/latch_wr_if.sv
// latch_wr_if: write/clear request handshake plus the latch-bank drive bus.
interface latch_wr_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             clr_req;
    logic [WIDTH-1:0] ld_d;
    logic [DEPTH-1:0] ld_gn;
    logic             ld_cd;
    logic             busy;
    logic             err;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, ld_d, ld_gn, ld_cd, busy, err
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, ld_d, ld_gn, ld_cd, busy, err
    );
endinterface

// File: rtl/latch_wr_timer.sv
// latch_wr_timer: loadable down-counter; done is high while the count sits at zero.
module latch_wr_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        done  = cnt_q == '0;
        cnt_d = load ? val : cnt_q - W'(!done);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/latch_wr_seq.sv
// latch_wr_seq: sequences setup -> gate -> hold writes into a bank of active-low-gated latches,
// plus bank-wide clear pulses on the shared active-low clear.
module latch_wr_seq
    import latch_wr_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 16,
    parameter int AW        = 3,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input logic       CP,
    input logic       CD,
    latch_wr_if.slave bus
);
    localparam int          CW  = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ld_d_q, ld_d_d;
    logic [DEPTH-1:0] ld_gn_q, ld_gn_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             ld_cd_q, ld_cd_d, busy_q, busy_d, err_q, err_d, clr_pend_q, clr_pend_d;
    logic             load, done, bad, pend_now;
    logic [CW-1:0]    load_val;

    latch_wr_timer #(.W(CW)) u_timer (
        .clk   (CP),
        .rst_n (CD),
        .load  (load),
        .val   (load_val),
        .done  (done)
    );

    // ld_cd_q low means reset was just released, so hold off writes until the clear lifts
    assign bus.wr_ready = state_q == IDLE && ld_cd_q && !bus.clr_req && !clr_pend_q;
    assign bad          = {1'b0, bus.wr_addr} >= LIM;
    assign pend_now     = clr_pend_q | bus.clr_req;

    always_comb begin
        state_d    = state_q;
        ld_d_d     = ld_d_q;
        ld_gn_d    = ld_gn_q;
        ld_cd_d    = ld_cd_q;
        err_d      = err_q;
        addr_d     = addr_q;
        clr_pend_d = clr_pend_q;
        load       = 1'b0;
        load_val   = '0;
        case (state_q)
            IDLE: begin
                ld_cd_d = 1'b1;
                if (bus.clr_req) begin
                    state_d    = CLEAR;
                    ld_cd_d    = 1'b0;
                    err_d      = 1'b0;
                    clr_pend_d = 1'b0;
                    load       = 1'b1;
                    load_val   = CW'(PULSE_CYC - 1);
                end else if (bus.wr_valid && bus.wr_ready) begin
                    state_d  = SETUP;
                    ld_d_d   = bus.wr_data;
                    addr_d   = bus.wr_addr;
                    err_d    = err_q | bad;
                    load     = 1'b1;
                    load_val = CW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                clr_pend_d = pend_now;
                if (done) begin
                    state_d  = PULSE;
                    ld_gn_d  = ~(DEPTH'(1) << addr_q);
                    load     = 1'b1;
                    load_val = CW'(PULSE_CYC - 1);
                end
            end
            PULSE: begin
                clr_pend_d = pend_now;
                if (done) begin
                    state_d  = HOLD;
                    ld_gn_d  = '1;
                    load     = 1'b1;
                    load_val = CW'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                clr_pend_d = pend_now;
                if (done) begin
                    state_d    = pend_now ? CLEAR : IDLE;
                    ld_cd_d    = !pend_now;
                    err_d      = pend_now ? 1'b0 : err_q;
                    clr_pend_d = 1'b0;
                    load       = pend_now;
                    load_val   = CW'(PULSE_CYC - 1);
                end
            end
            CLEAR: begin
                if (done) begin
                    state_d = IDLE;
                    ld_cd_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge CP or negedge CD)
        if (!CD) begin
            state_q    <= IDLE;
            ld_d_q     <= '0;
            ld_gn_q    <= '1;
            ld_cd_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            ld_d_q     <= ld_d_d;
            ld_gn_q    <= ld_gn_d;
            ld_cd_q    <= ld_cd_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            clr_pend_q <= clr_pend_d;
            addr_q     <= addr_d;
        end

    assign bus.ld_d  = ld_d_q;
    assign bus.ld_gn = ld_gn_q;
    assign bus.ld_cd = ld_cd_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_latch_wr_seq.sv
// tb_latch_wr_seq: directed and random stimulus checked every cycle against a timeline model of the sequencer.
module tb_latch_wr_seq;
    localparam int DEPTH = 8, WIDTH = 16, AW = 4, S = 1, P = 2, H = 1;

    logic CP = 1'b0;
    logic CD = 1'b0;
    int   checks = 0;
    int   passes = 0;

    latch_wr_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) bus ();

    latch_wr_seq #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW),
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut (
        .CP  (CP),
        .CD  (CD),
        .bus (bus)
    );

    always #5 CP = ~CP;

    // Model: an operation is a start edge plus a kind; outputs follow from elapsed edges.
    typedef enum {NONE, WR, CL} op_t;
    op_t              m_op;
    int               n, m_start, m_addr;
    bit               m_pend, m_cd_ok, m_err;
    logic [WIDTH-1:0] m_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_op = NONE; n = 0; m_start = 0; m_addr = 0;
        m_pend = 0; m_cd_ok = 0; m_err = 0; m_d = '0;
    endtask

    task automatic model_step();
        n++;
        if (m_op == WR) begin
            m_pend |= bus.clr_req;
            if (n - m_start == S + P + H) begin
                if (m_pend) begin
                    m_op = CL; m_start = n; m_pend = 0; m_err = 0;
                end else m_op = NONE;
            end
        end else if (m_op == CL) begin
            if (n - m_start == P) m_op = NONE;
        end else if (bus.clr_req) begin
            m_op = CL; m_start = n; m_err = 0;
        end else if (bus.wr_valid && m_cd_ok) begin
            m_op = WR; m_start = n; m_addr = int'(bus.wr_addr); m_d = bus.wr_data;
            if (m_addr >= DEPTH) m_err = 1;
        end
        m_cd_ok = 1;
    endtask

    task automatic compare();
        int               e;
        logic [DEPTH-1:0] gn;
        e  = n - m_start;
        gn = '1;
        if (m_op == WR && e >= S && e < S + P && m_addr < DEPTH) gn[m_addr] = 1'b0;
        chk("ld_gn", 32'(bus.ld_gn), 32'(gn));
        chk("ld_cd", 32'(bus.ld_cd), 32'(m_cd_ok && m_op != CL));
        chk("ld_d", 32'(bus.ld_d), 32'(m_d));
        chk("busy", 32'(bus.busy), 32'(m_op != NONE));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("wr_ready", 32'(bus.wr_ready), 32'(m_op == NONE && m_cd_ok && !bus.clr_req));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CP or negedge CD);
            if (!CD) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(posedge CP);
        #1;
        compare();
    end

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic c);
        @(negedge CP);
        bus.wr_valid = v; bus.wr_addr = a; bus.wr_data = d; bus.clr_req = c;
    endtask

    task automatic tick();
        @(posedge CP);
        #2;
    endtask

    initial begin
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.clr_req = 0;
        repeat (3) @(posedge CP);
        #2;
        chk("rst_gn", 32'(bus.ld_gn), 32'h00FF);
        chk("rst_cd", 32'(bus.ld_cd), 32'h0);
        chk("rst_d", 32'(bus.ld_d), 32'h0);
        chk("rst_ready", 32'(bus.wr_ready), 32'h0);
        @(negedge CP);
        CD = 1'b1;
        tick();
        chk("rel_cd", 32'(bus.ld_cd), 32'h1);
        chk("rel_ready", 32'(bus.wr_ready), 32'h1);

        drive(1, 4'd5, 16'hA5C3, 0);
        tick();
        chk("w_d", 32'(bus.ld_d), 32'hA5C3);
        chk("w_gn_k", 32'(bus.ld_gn), 32'h00FF);
        drive(0, 4'd0, 16'h0, 0);
        tick(); chk("w_gn_k1", 32'(bus.ld_gn), 32'h00DF);
        tick(); chk("w_gn_k2", 32'(bus.ld_gn), 32'h00DF);
        tick(); chk("w_gn_k3", 32'(bus.ld_gn), 32'h00FF);
        chk("w_d_hold", 32'(bus.ld_d), 32'hA5C3);
        tick(); chk("w_ready_k4", 32'(bus.wr_ready), 32'h1);

        drive(1, 4'd0, 16'h1111, 0);
        tick(); chk("b2b_d0", 32'(bus.ld_d), 32'h1111);
        drive(1, 4'd7, 16'h2222, 0);
        repeat (4) tick();
        chk("b2b_d_kept", 32'(bus.ld_d), 32'h1111);
        tick(); chk("b2b_d1", 32'(bus.ld_d), 32'h2222);
        drive(0, 4'd0, 16'h0, 0);
        repeat (5) tick();

        drive(1, 4'd3, 16'hBEEF, 1);
        tick();
        chk("race_cd0", 32'(bus.ld_cd), 32'h0);
        chk("race_no_wr", 32'(bus.ld_d), 32'h2222);
        drive(0, 4'd0, 16'h0, 0);
        tick(); chk("race_cd1", 32'(bus.ld_cd), 32'h0);
        tick(); chk("race_cd2", 32'(bus.ld_cd), 32'h1);

        drive(1, 4'd1, 16'h1234, 0);
        tick();
        drive(0, 4'd0, 16'h0, 0);
        tick();
        drive(0, 4'd0, 16'h0, 1);
        tick();
        drive(0, 4'd0, 16'h0, 0);
        tick(); chk("pend_hold_cd", 32'(bus.ld_cd), 32'h1);
        tick(); chk("pend_cd0", 32'(bus.ld_cd), 32'h0);
        tick(); chk("pend_cd1", 32'(bus.ld_cd), 32'h0);
        tick(); chk("pend_cd_up", 32'(bus.ld_cd), 32'h1);

        drive(1, 4'd8, 16'h5555, 0);
        tick(); chk("bad_err", 32'(bus.err), 32'h1);
        drive(0, 4'd0, 16'h0, 0);
        repeat (3) begin
            tick(); chk("bad_gn", 32'(bus.ld_gn), 32'h00FF);
        end
        tick(); chk("bad_idle", 32'(bus.busy), 32'h0);
        drive(0, 4'd0, 16'h0, 1);
        tick(); chk("bad_err_clr", 32'(bus.err), 32'h0);
        drive(0, 4'd0, 16'h0, 0);
        repeat (2) tick();

        drive(1, 4'd2, 16'h7777, 0);
        tick();
        drive(0, 4'd0, 16'h0, 0);
        tick(); chk("mid_gn", 32'(bus.ld_gn), 32'h00FB);
        #1 CD = 1'b0;
        #1;
        chk("mid_rst_gn", 32'(bus.ld_gn), 32'h00FF);
        chk("mid_rst_cd", 32'(bus.ld_cd), 32'h0);
        @(negedge CP);
        CD = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 9)), WIDTH'($urandom),
                  $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                CD = 1'b0;
                @(negedge CP);
                CD = 1'b1;
            end
        end
        drive(0, 4'd0, 16'h0, 0);
        repeat (10) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
